// File: rtl/avalon_ram_if.sv
// Avalon-MM bus bundle between the CPU bus master and avalon_ram.
//   address      32  byte address (bits [1:0] ignored by the RAM)
//   write/read    1  access requests, held by the master while waitrequest=1
//   writedata    32  write data
//   byteenable    4  lane enables, bit i gates writedata[8i+7:8i]
//   waitrequest   1  slave stall
//   readdata     32  slave read data
interface avalon_ram_if;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/avalon_ram.sv
// avalon_ram: word-organised simulation RAM, Avalon-MM slave for top_level_CPU.
// Two windows: instruction window at the MIPS reset vector and a data window.
// Unmapped reads return 0, unmapped writes are dropped.
// Ports:
//   clk          clock, bus activity on the rising edge
//   RAM_Reset    synchronous active-high reset (clears all words, readdata)
//   bus          Avalon-MM slave modport (avalon_ram_if)
//   instruction  backdoor load word
//   inst_input   backdoor load enable (level)
//   inst_addr    backdoor byte offset into the instruction window
// Build option: define RAM_WAITSTATE_EN for one wait state per access
// (IDLE/ACK FSM, registered readdata); otherwise zero-wait with a
// combinational read path.
module avalon_ram #(
  parameter logic [31:0] INST_BASE  = 32'hBFC00000,
  parameter int unsigned INST_WORDS = 64,
  parameter logic [31:0] DATA_BASE  = 32'h00001000,
  parameter int unsigned DATA_WORDS = 256
) (
  input  logic              clk,
  input  logic              RAM_Reset,
  avalon_ram_if.slave       bus,
  input  logic [31:0]       instruction,
  input  logic              inst_input,
  input  logic [7:0]        inst_addr
);

  localparam int unsigned IW = $clog2(INST_WORDS);
  localparam int unsigned DW = $clog2(DATA_WORDS);

  logic [31:0]   inst_mem [INST_WORDS];
  logic [31:0]   data_mem [DATA_WORDS];

  logic [31:0]   inst_off;
  logic [31:0]   data_off;
  logic          in_inst;
  logic          in_data;
  logic [IW-1:0] inst_idx;
  logic [DW-1:0] data_idx;
  logic [IW-1:0] bd_idx;
  logic [31:0]   rd_word;
  logic          do_write;

  // Unsigned wrap makes one compare per window sufficient.
  assign inst_off = bus.address - INST_BASE;
  assign data_off = bus.address - DATA_BASE;
  assign in_inst  = inst_off < 32'(4 * INST_WORDS);
  assign in_data  = data_off < 32'(4 * DATA_WORDS);
  assign inst_idx = inst_off[IW+1:2];
  assign data_idx = data_off[DW+1:2];
  assign bd_idx   = inst_addr[IW+1:2];

  // The backdoor is stored on every edge while inst_input is held and is
  // also bypassed onto the read path, so a word presented between edges is
  // visible immediately and the level-sensitive load is never hidden.
  always_comb begin
    rd_word = '0;
    if (in_inst) begin
      if (inst_input && (inst_idx == bd_idx))
        rd_word = instruction;
      else
        rd_word = inst_mem[inst_idx];
    end else if (in_data) begin
      rd_word = data_mem[data_idx];
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  be);
    merge = old_w;
    for (int unsigned i = 0; i < 4; i++)
      if (be[i]) merge[8*i +: 8] = new_w[8*i +: 8];
  endfunction

  // Backdoor assignment comes last so it wins over reset and a bus write.
  always_ff @(posedge clk) begin
    if (RAM_Reset) begin
      for (int unsigned i = 0; i < INST_WORDS; i++) inst_mem[i] <= '0;
      for (int unsigned i = 0; i < DATA_WORDS; i++) data_mem[i] <= '0;
    end else if (do_write) begin
      if (in_inst)
        inst_mem[inst_idx] <= merge(inst_mem[inst_idx], bus.writedata, bus.byteenable);
      else if (in_data)
        data_mem[data_idx] <= merge(data_mem[data_idx], bus.writedata, bus.byteenable);
    end
    if (inst_input) inst_mem[bd_idx] <= instruction;
  end

`ifdef RAM_WAITSTATE_EN
  typedef enum logic {IDLE, ACK} state_t;
  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (RAM_Reset) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next      = state;
    bus.waitrequest = 1'b0;
    case (state)
      IDLE: if (bus.read || bus.write) begin
        bus.waitrequest = 1'b1;
        state_next      = ACK;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign do_write = bus.write && (state == ACK);

  // A simultaneous write takes priority; readdata then holds its old value.
  always_ff @(posedge clk) begin
    if (RAM_Reset)
      bus.readdata <= '0;
    else if ((state == ACK) && bus.read && !bus.write)
      bus.readdata <= rd_word;
  end

  logic unused_ok;
  assign unused_ok = ^{inst_off[31:IW+2], inst_off[1:0],
                       data_off[31:DW+2], data_off[1:0], inst_addr[1:0]};
`else
  assign bus.waitrequest = 1'b0;
  assign bus.readdata    = rd_word;
  assign do_write        = bus.write;

  logic unused_ok;
  assign unused_ok = ^{inst_off[31:IW+2], inst_off[1:0],
                       data_off[31:DW+2], data_off[1:0], inst_addr[1:0],
                       bus.read};
`endif

endmodule

// File: tb/tb_avalon_ram.sv
module tb_avalon_ram;
  localparam logic [31:0] INST_BASE  = 32'hBFC00000;
  localparam int unsigned INST_WORDS = 64;
  localparam logic [31:0] DATA_BASE  = 32'h00001000;
  localparam int unsigned DATA_WORDS = 256;

  logic        clk = 1'b0;
  logic        RAM_Reset;
  logic [31:0] instruction;
  logic        inst_input;
  logic [7:0]  inst_addr;

  avalon_ram_if bus();

  avalon_ram #(
    .INST_BASE (INST_BASE),
    .INST_WORDS(INST_WORDS),
    .DATA_BASE (DATA_BASE),
    .DATA_WORDS(DATA_WORDS)
  ) dut (
    .clk        (clk),
    .RAM_Reset  (RAM_Reset),
    .bus        (bus),
    .instruction(instruction),
    .inst_input (inst_input),
    .inst_addr  (inst_addr)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passed = 0;

  // Reference contents of both windows, as seen over the bus.
  logic [31:0] inst_m [INST_WORDS];
  logic [31:0] data_m [DATA_WORDS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < INST_WORDS; i++) inst_m[i] = 32'h0;
    for (int i = 0; i < DATA_WORDS; i++) data_m[i] = 32'h0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a >= INST_BASE && a < INST_BASE + 4 * INST_WORDS)
      return inst_m[(a - INST_BASE) / 4];
    if (a >= DATA_BASE && a < DATA_BASE + 4 * DATA_WORDS)
      return data_m[(a - DATA_BASE) / 4];
    return 32'h0;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if (a >= INST_BASE && a < INST_BASE + 4 * INST_WORDS)
      inst_m[(a - INST_BASE) / 4] = (inst_m[(a - INST_BASE) / 4] & ~mask) | (d & mask);
    else if (a >= DATA_BASE && a < DATA_BASE + 4 * DATA_WORDS)
      data_m[(a - DATA_BASE) / 4] = (data_m[(a - DATA_BASE) / 4] & ~mask) | (d & mask);
  endfunction

  // One Avalon transfer: hold the request until an edge with waitrequest low.
  task automatic bus_op(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] rdata);
    logic done;
    logic stall;
    done = 1'b0;
    @(negedge clk);
    bus.address = a; bus.read = rd; bus.write = wr;
    bus.writedata = d; bus.byteenable = be;
    for (int n = 0; n < 10 && !done; n++) begin
      #1 stall = bus.waitrequest;
      @(posedge clk);
      if (stall === 1'b0) done = 1'b1;
      else @(negedge clk);
    end
    #1 bus.read = 1'b0; bus.write = 1'b0;
    #1 rdata = bus.readdata;
    check("bus_handshake_done", {31'b0, done}, 32'd1);
  endtask

  task automatic bd_load(input logic [7:0] off, input logic [31:0] val);
    @(negedge clk);
    inst_addr = off; inst_input = 1'b1;
    instruction = $urandom(); #1;
    instruction = $urandom(); #1;
    instruction = val;
    @(posedge clk); #1;
    inst_input = 1'b0;
    inst_m[off[7:2]] = val;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    RAM_Reset = 1'b1;
    @(posedge clk); #1;
    RAM_Reset = 1'b0;
  endtask

  initial begin
    logic [31:0] r, a, d, prev;
    logic [3:0]  be;

    RAM_Reset = 1'b1; inst_input = 1'b0; inst_addr = 8'h0; instruction = 32'h0;
    bus.address = 32'h0; bus.read = 1'b0; bus.write = 1'b0;
    bus.writedata = 32'h0; bus.byteenable = 4'h0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 RAM_Reset = 1'b0;
    check("reset_waitrequest", {31'b0, bus.waitrequest}, 32'd0);
    check("reset_readdata", bus.readdata, 32'h0);

    // Backdoor load then bus read at the reset vector + 4.
    bd_load(8'h04, 32'h24020010);
    bus_op(INST_BASE + 4, 1'b1, 1'b0, 32'h0, 4'h0, r);
    check("backdoor_read", r, 32'h24020010);

`ifdef RAM_WAITSTATE_EN
    @(negedge clk);
    bus.address = INST_BASE + 4; bus.read = 1'b1;
    #1 check("ws_cycle0_wait", {31'b0, bus.waitrequest}, 32'd1);
    @(posedge clk);
    #1 check("ws_cycle1_wait", {31'b0, bus.waitrequest}, 32'd0);
    @(posedge clk);
    #1 bus.read = 1'b0;
    check("ws_readdata", bus.readdata, 32'h24020010);
    #1 check("ws_idle_wait", {31'b0, bus.waitrequest}, 32'd0);
`else
    @(negedge clk);
    bus.address = INST_BASE + 4; bus.read = 1'b1;
    #1 check("zw_wait", {31'b0, bus.waitrequest}, 32'd0);
    check("zw_comb_readdata", bus.readdata, 32'h24020010);
    @(posedge clk);
    #1 bus.read = 1'b0;
`endif

    // Byte-lane write into a cleared data word.
    bus_op(DATA_BASE, 1'b0, 1'b1, 32'hAABBCCDD, 4'b0101, r);
    model_write(DATA_BASE, 32'hAABBCCDD, 4'b0101);
    bus_op(DATA_BASE, 1'b1, 1'b0, 32'h0, 4'h0, r);
    check("byte_write", r, 32'h00BB00DD);

    // Unmapped write is dropped; sweep both windows against the model.
    bus_op(32'h00000040, 1'b0, 1'b1, 32'h12345678, 4'hF, r);
    bus_op(32'h00000040, 1'b1, 1'b0, 32'h0, 4'h0, r);
    check("unmapped_read", r, 32'h0);
    for (int i = 0; i < INST_WORDS; i++) begin
      bus_op(INST_BASE + 4 * i, 1'b1, 1'b0, 32'h0, 4'hF, r);
      check("sweep_inst", r, inst_m[i]);
    end
    for (int i = 0; i < DATA_WORDS; i++) begin
      bus_op(DATA_BASE + 4 * i, 1'b1, 1'b0, 32'h0, 4'hF, r);
      check("sweep_data", r, data_m[i]);
    end

    // read and write together: write happens, registered readdata holds.
    prev = bus.readdata;
    bus_op(DATA_BASE + 8, 1'b1, 1'b1, 32'h5A5A1234, 4'hF, r);
    model_write(DATA_BASE + 8, 32'h5A5A1234, 4'hF);
`ifdef RAM_WAITSTATE_EN
    check("rdwr_readdata_held", r, prev);
`endif
    bus_op(DATA_BASE + 8, 1'b1, 1'b0, 32'h0, 4'h0, r);
    check("rdwr_write_done", r, 32'h5A5A1234);

    // Backdoor wins over a bus write to the same word.
    @(negedge clk);
    inst_addr = 8'h08; instruction = 32'hCAFEF00D; inst_input = 1'b1;
    bus_op(INST_BASE + 8, 1'b0, 1'b1, 32'h11111111, 4'hF, r);
    inst_input = 1'b0;
    inst_m[2] = 32'hCAFEF00D;
    bus_op(INST_BASE + 8, 1'b1, 1'b0, 32'h0, 4'h0, r);
    check("backdoor_over_write", r, 32'hCAFEF00D);

    // Randomised traffic against the model, including window edges.
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 5))
        0, 1: a = INST_BASE + 4 * $urandom_range(0, INST_WORDS - 1);
        2, 3: a = DATA_BASE + 4 * $urandom_range(0, DATA_WORDS - 1);
        4: case ($urandom_range(0, 5))
             0: a = INST_BASE - 4;
             1: a = INST_BASE + 4 * INST_WORDS;
             2: a = INST_BASE + 4 * (INST_WORDS - 1);
             3: a = DATA_BASE - 4;
             4: a = DATA_BASE + 4 * DATA_WORDS;
             default: a = DATA_BASE + 4 * (DATA_WORDS - 1);
           endcase
        default: a = $urandom();
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      d  = $urandom();
      be = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) begin
        bd_load(8'($urandom_range(0, 255)), d);
      end else if ($urandom_range(0, 1) == 0) begin
        bus_op(a, 1'b0, 1'b1, d, be, r);
        model_write(a, d, be);
      end else begin
        bus_op(a, 1'b1, 1'b0, 32'h0, be, r);
        check("random_read", r, model_read(a));
      end
    end

    // Backdoor wins over reset.
    @(negedge clk);
    inst_addr = 8'h0C; instruction = 32'h0BADBEEF; inst_input = 1'b1;
    RAM_Reset = 1'b1;
    @(posedge clk); #1;
    RAM_Reset = 1'b0; inst_input = 1'b0;
    model_clear();
    inst_m[3] = 32'h0BADBEEF;
    bus_op(INST_BASE + 12, 1'b1, 1'b0, 32'h0, 4'h0, r);
    check("backdoor_over_reset", r, 32'h0BADBEEF);
    bus_op(DATA_BASE + 8, 1'b1, 1'b0, 32'h0, 4'h0, r);
    check("reset_cleared_data", r, 32'h0);

    // Plain reset: every word reads back 0.
    reset_pulse();
    model_clear();
    check("reset2_waitrequest", {31'b0, bus.waitrequest}, 32'd0);
    check("reset2_readdata", bus.readdata, 32'h0);
    for (int i = 0; i < INST_WORDS; i++) begin
      bus_op(INST_BASE + 4 * i, 1'b1, 1'b0, 32'h0, 4'hF, r);
      check("reset_inst", r, inst_m[i]);
    end
    for (int i = 0; i < DATA_WORDS; i++) begin
      bus_op(DATA_BASE + 4 * i, 1'b1, 1'b0, 32'h0, 4'hF, r);
      check("reset_data", r, data_m[i]);
    end
    #1 check("final_waitrequest", {31'b0, bus.waitrequest}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
